// File: rtl/game_sequencer.sv
// Game-flow controller: sequences menu, countdown, play, death and victory phases
// and tracks lives, level and per-level play time for the obstacle game.
module game_sequencer #(
    parameter int unsigned LIVES           = 3,
    parameter int unsigned NUM_LEVELS      = 3,
    parameter int unsigned COUNTDOWN_TICKS = 72,
    parameter int unsigned DEATH_TICKS     = 48,
    parameter int unsigned LEVEL_TICKS     = 1200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        start_btn,
    input  logic        collision,
    output logic [2:0]  state,
    output logic        menu_screen,
    output logic        victory_screen,
    output logic        player_death,
    output logic        run_en,
    output logic        jump_en,
    output logic        counter_clr,
    output logic [1:0]  lives,
    output logic [1:0]  level,
    output logic [10:0] game_time
);

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_DEATH     = 3'd3,
        ST_VICTORY   = 3'd4
    } state_t;

    localparam logic [7:0]  CD_LOAD    = 8'(COUNTDOWN_TICKS);
    localparam logic [7:0]  DT_LOAD    = 8'(DEATH_TICKS);
    localparam logic [10:0] TIME_LAST  = 11'(LEVEL_TICKS - 1);
    localparam logic [1:0]  LEVEL_LAST = 2'(NUM_LEVELS - 1);
    localparam logic [1:0]  LIVES_LOAD = 2'(LIVES);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cd, w_cd_nxt;
    logic [7:0]  r_dt, w_dt_nxt;
    logic [1:0]  r_lives, w_lives_nxt;
    logic [1:0]  r_level, w_level_nxt;
    logic [10:0] r_time, w_time_nxt;
    logic        r_btn, r_btn_prev, r_armed;
    logic        w_start_rise;

    // r_armed stays low until the button is seen released after reset, so a
    // button held through reset cannot start a game when reset lifts.
    assign w_start_rise = r_btn & ~r_btn_prev & r_armed;

    always_comb begin
        w_state_nxt = r_state;
        w_cd_nxt    = r_cd;
        w_dt_nxt    = r_dt;
        w_lives_nxt = r_lives;
        w_level_nxt = r_level;
        w_time_nxt  = r_time;
        case (r_state)
            ST_MENU: begin
                if (w_start_rise) begin
                    w_lives_nxt = LIVES_LOAD;
                    w_level_nxt = '0;
                    w_time_nxt  = '0;
                    w_cd_nxt    = CD_LOAD;
                    w_state_nxt = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    w_cd_nxt = r_cd - 8'd1;
                    if (r_cd == 8'd1) w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (collision) begin
                    w_lives_nxt = r_lives - 2'd1;
                    w_dt_nxt    = DT_LOAD;
                    w_state_nxt = ST_DEATH;
                end else if (tick) begin
                    if (r_time == TIME_LAST) begin
                        if (r_level == LEVEL_LAST) begin
                            w_state_nxt = ST_VICTORY;
                        end else begin
                            w_level_nxt = r_level + 2'd1;
                            w_time_nxt  = '0;
                            w_cd_nxt    = CD_LOAD;
                            w_state_nxt = ST_COUNTDOWN;
                        end
                    end else begin
                        w_time_nxt = r_time + 11'd1;
                    end
                end
            end
            ST_DEATH: begin
                if (tick) begin
                    w_dt_nxt = r_dt - 8'd1;
                    if (r_dt == 8'd1) begin
                        if (r_lives == 2'd0) begin
                            w_state_nxt = ST_MENU;
                        end else begin
                            w_time_nxt  = '0;
                            w_cd_nxt    = CD_LOAD;
                            w_state_nxt = ST_COUNTDOWN;
                        end
                    end
                end
            end
            ST_VICTORY: begin
                if (w_start_rise) w_state_nxt = ST_MENU;
            end
            default: w_state_nxt = ST_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_MENU;
            r_cd           <= '0;
            r_dt           <= '0;
            r_lives        <= '0;
            r_level        <= '0;
            r_time         <= '0;
            r_btn          <= 1'b0;
            r_btn_prev     <= 1'b0;
            r_armed        <= 1'b0;
            menu_screen    <= 1'b1;
            victory_screen <= 1'b0;
            player_death   <= 1'b0;
            run_en         <= 1'b0;
            jump_en        <= 1'b0;
            counter_clr    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cd           <= w_cd_nxt;
            r_dt           <= w_dt_nxt;
            r_lives        <= w_lives_nxt;
            r_level        <= w_level_nxt;
            r_time         <= w_time_nxt;
            r_btn          <= start_btn;
            r_btn_prev     <= r_btn;
            r_armed        <= r_armed | ~start_btn;
            // Flags decode the next state so they switch on the same edge as state.
            menu_screen    <= (w_state_nxt == ST_MENU);
            victory_screen <= (w_state_nxt == ST_VICTORY);
            player_death   <= (w_state_nxt == ST_DEATH);
            run_en         <= (w_state_nxt == ST_PLAY);
            jump_en        <= (w_state_nxt == ST_PLAY);
            counter_clr    <= (w_state_nxt == ST_COUNTDOWN) && (r_state != ST_COUNTDOWN);
        end
    end

    assign state     = r_state;
    assign lives     = r_lives;
    assign level     = r_level;
    assign game_time = r_time;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised bench for game_sequencer: every cycle is compared against a
// phase/tick-count model, plus targeted checks on the scenarios of interest.
module tb_game_sequencer;

    localparam int LIVES_P = 3;
    localparam int LEVELS_P = 3;
    localparam int CD_P = 72;
    localparam int DT_P = 48;
    localparam int LT_P = 1200;

    localparam int P_MENU = 0;
    localparam int P_CD = 1;
    localparam int P_PLAY = 2;
    localparam int P_DEATH = 3;
    localparam int P_VIC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        start_btn = 1'b0;
    logic        collision = 1'b0;
    logic [2:0]  state;
    logic        menu_screen, victory_screen, player_death, run_en, jump_en, counter_clr;
    logic [1:0]  lives, level;
    logic [10:0] game_time;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model: phase, counters of ticks spent in the timed phase, and button history.
    int m_phase, m_lives, m_level, m_time, m_phase_ticks;
    bit m_clr, m_b1, m_b2, m_seen_low;

    game_sequencer #(
        .LIVES(LIVES_P), .NUM_LEVELS(LEVELS_P), .COUNTDOWN_TICKS(CD_P),
        .DEATH_TICKS(DT_P), .LEVEL_TICKS(LT_P)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start_btn(start_btn),
        .collision(collision), .state(state), .menu_screen(menu_screen),
        .victory_screen(victory_screen), .player_death(player_death),
        .run_en(run_en), .jump_en(jump_en), .counter_clr(counter_clr),
        .lives(lives), .level(level), .game_time(game_time)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic enter_countdown();
        m_phase = P_CD;
        m_phase_ticks = 0;
    endtask

    task automatic model_edge(input bit rst, input bit b, input bit t, input bit c);
        int prev;
        bit rise;
        if (rst) begin
            m_phase = P_MENU; m_lives = 0; m_level = 0; m_time = 0;
            m_phase_ticks = 0; m_clr = 0; m_b1 = 0; m_b2 = 0; m_seen_low = 0;
        end else begin
            rise = m_b1 && !m_b2 && m_seen_low;
            prev = m_phase;
            case (m_phase)
                P_MENU: if (rise) begin
                    m_lives = LIVES_P; m_level = 0; m_time = 0;
                    enter_countdown();
                end
                P_CD: if (t) begin
                    m_phase_ticks++;
                    if (m_phase_ticks == CD_P) m_phase = P_PLAY;
                end
                P_PLAY: begin
                    if (c) begin
                        m_lives--;
                        m_phase = P_DEATH;
                        m_phase_ticks = 0;
                    end else if (t) begin
                        if (m_time + 1 == LT_P) begin
                            if (m_level + 1 == LEVELS_P) m_phase = P_VIC;
                            else begin
                                m_level++; m_time = 0;
                                enter_countdown();
                            end
                        end else m_time++;
                    end
                end
                P_DEATH: if (t) begin
                    m_phase_ticks++;
                    if (m_phase_ticks == DT_P) begin
                        if (m_lives == 0) m_phase = P_MENU;
                        else begin
                            m_time = 0;
                            enter_countdown();
                        end
                    end
                end
                default: if (rise) m_phase = P_MENU;
            endcase
            m_clr = (m_phase == P_CD) && (prev != P_CD);
            m_b2 = m_b1;
            m_b1 = b;
            if (!b) m_seen_low = 1;
        end
    endtask

    function automatic logic [23:0] model_vec();
        return {3'(m_phase), (m_phase == P_MENU), (m_phase == P_VIC), (m_phase == P_DEATH),
                (m_phase == P_PLAY), (m_phase == P_PLAY), m_clr,
                2'(m_lives), 2'(m_level), 11'(m_time)};
    endfunction

    task automatic step(input bit b, input bit t, input bit c);
        start_btn = b; tick = t; collision = c;
        @(posedge clk);
        model_edge(!reset_n, b, t, c);
        #1;
        check("cyc", {8'h0, state, menu_screen, victory_screen, player_death, run_en, jump_en,
                      counter_clr, lives, level, game_time}, {8'h0, model_vec()});
    endtask

    // Step with random ticks until the DUT reaches phase st; counts ticks and clr pulses on the way.
    task automatic wait_phase(input string tag, input int st, input int max_cyc, input bit b,
                              output int ticks_seen, output int clr_seen);
        bit t;
        ticks_seen = 0;
        clr_seen = 0;
        for (int i = 0; i < max_cyc && int'(state) != st; i++) begin
            t = 1'($urandom_range(0, 1));
            if (t) ticks_seen++;
            step(b, t, 1'b0);
            if (counter_clr) clr_seen++;
        end
        check(tag, 32'(state), 32'(st));
    endtask

    task automatic do_reset(input bit b);
        reset_n = 1'b0;
        step(b, 1'b0, 1'b0);
        step(b, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic start_game();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int tk, cl;
        bit t;

        // Reset and start
        do_reset(1'b0);
        check("rst_state", 32'(state), P_MENU);
        check("rst_menu", 32'(menu_screen), 1);
        check("rst_flags", {26'h0, victory_screen, player_death, run_en, jump_en, counter_clr, 1'b0}, 0);
        check("rst_counts", {17'h0, lives, level, game_time}, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("start_lat1", 32'(state), P_MENU);
        step(1'b1, 1'b0, 1'b0);
        check("start_lat2", 32'(state), P_CD);
        check("start_clr", 32'(counter_clr), 1);
        check("start_lives", 32'(lives), LIVES_P);
        check("start_level", 32'(level), 0);
        step(1'b1, 1'b0, 1'b0);
        check("clr_once", 32'(counter_clr), 0);

        // Countdown length
        wait_phase("cd_to_play", P_PLAY, 1000, 1'b0, tk, cl);
        check("cd_ticks", 32'(tk), CD_P);
        check("cd_run_jump", {30'h0, run_en, jump_en}, 3);
        check("cd_no_clr", 32'(cl), 0);

        // Level progression through to victory
        wait_phase("to_victory", P_VIC, 20000, 1'b0, tk, cl);
        check("lvl_clr_pulses", 32'(cl), LEVELS_P - 1);
        check("vic_time", 32'(game_time), LT_P - 1);
        check("vic_level", 32'(level), LEVELS_P - 1);
        check("vic_screen", 32'(victory_screen), 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("vic_to_menu", 32'(state), P_MENU);
        step(1'b0, 1'b0, 1'b0);

        // Death and game over
        start_game();
        for (int k = 0; k < LIVES_P; k++) begin
            wait_phase("death_play", P_PLAY, 1000, 1'b0, tk, cl);
            repeat ($urandom_range(0, 30)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            check("death_state", 32'(state), P_DEATH);
            check("death_flag", 32'(player_death), 1);
            check("death_lives", 32'(lives), LIVES_P - 1 - k);
            wait_phase("death_exit", (k < LIVES_P - 1) ? P_CD : P_MENU, 1000, 1'b0, tk, cl);
            check("death_ticks", 32'(tk), DT_P);
            check("death_level", 32'(level), 0);
        end
        check("gameover_lives", 32'(lives), 0);

        // Collision on the completing tick
        start_game();
        wait_phase("sim_play", P_PLAY, 1000, 1'b0, tk, cl);
        for (int i = 0; i < 2000 && game_time != 11'(LT_P - 1); i++) step(1'b0, 1'b1, 1'b0);
        check("sim_time", 32'(game_time), LT_P - 1);
        step(1'b0, 1'b1, 1'b1);
        check("sim_state", 32'(state), P_DEATH);
        check("sim_lives", 32'(lives), LIVES_P - 1);
        check("sim_level", 32'(level), 0);

        // Held button through a game and through a mid-play reset
        do_reset(1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        wait_phase("hold_play", P_PLAY, 1000, 1'b1, tk, cl);
        check("hold_one_clr", 32'(cl), 1);
        repeat (20) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check("hold_stay_play", 32'(state), P_PLAY);
        do_reset(1'b1);
        repeat (5) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check("hold_no_auto", 32'(state), P_MENU);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        check("release_menu", 32'(state), P_MENU);

        // Random soak
        for (int i = 0; i < 6000; i++) begin
            t = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 7) == 0), t, ($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
